inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage sitting directly upstream of inst_ram (single-port BRAM, 1-cycle read latency).
//  Holds the PC, drives the BRAM enable/word address, and captures douta one cycle later.
//  Presents {pc, instruction} pairs to decode through a valid/ready handshake, with a 2-entry output queue
//  so back-pressure never loses a returning word; supports PC redirect (branch/jump) with in-flight flush.
// PARAMETERS
//  ADDR_W    17            BRAM word-address width (inst_ram addra)
//  RESET_PC  32'h0000_0000 byte PC loaded at reset; bits [1:0] must be 0
// PORTS
//  clk             in   1       system clock, all state on rising edge
//  resetn          in   1       asynchronous, active-low reset
//  redirect_valid  in   1       load new PC this cycle, flush everything in flight
//  redirect_pc     in   32      byte target PC; bits [1:0] ignored (forced 0)
//  inst_en         out  1       BRAM ena; a read is issued on this edge when 1
//  inst_addr       out  ADDR_W  BRAM word address = pc[ADDR_W+1:2]
//  inst_rdata      in   32      BRAM douta, valid the cycle after inst_en
//  out_valid       out  1       queue head holds a valid instruction
//  out_ready       in   1       decode accepts head this cycle
//  out_pc          out  32      byte PC of head instruction
//  out_inst        out  32      head instruction word
// BEHAVIOUR
//  Reset (async, resetn=0): pc=RESET_PC, pend=0, count=0, queue entries=0; out_valid=0, out_pc=0, out_inst=0;
//   inst_en forced 0 while resetn=0. First read issued in the first cycle with resetn=1.
//  State: pc[31:0]; pend (read issued last edge, data on inst_rdata now) + pend_pc[31:0]; 2-entry FIFO, count 0..2.
//  pop   = out_valid & out_ready; out_valid = (count!=0); out_pc/out_inst = FIFO head (registered).
//  issue = ~redirect_valid & ((count + pend - pop) < 2); inst_en = issue (combinational from out_ready, redirect_valid).
//  On issue: pend<=1, pend_pc<=pc, pc<=pc+4 (32-bit wrap 0xFFFF_FFFC->0); else pend<=0.
//  inst_addr = pc[ADDR_W+1:2]; wraps naturally at 2^ADDR_W words while pc keeps counting.
//  When pend=1 and no redirect: push {pend_pc, inst_rdata} into FIFO. Credit rule guarantees no overflow;
//   simultaneous push+pop keeps count, head advances, new entry lands at tail.
//  Latency: read issued edge N -> data captured edge N+1 -> out_valid=1 during cycle after edge N+1.
//  Throughput: 1 instruction/cycle with out_ready held 1 (steady state pend=1, count=1).
//  Back-pressure: out_ready=0 -> at most 2 words buffered (count+pend<=2), then inst_en=0, pc frozen;
//   out_pc/out_inst/out_valid stable while out_valid & ~out_ready.
//  Redirect (redirect_valid=1) has priority: a pop in the same cycle is a completed transfer;
//   then FIFO cleared (count<=0), pend<=0 (returning BRAM word discarded), pc<={redirect_pc[31:2],2'b00},
//   inst_en=0 that cycle. Target read issued the next cycle; out_valid=0 for exactly 2 cycles after redirect.
//  Back-to-back redirects: last one wins; no stale instruction is ever presented.
//  Reset mid-operation: all state cleared immediately (async); restart from RESET_PC.
// TESTING
//  T1 BRAM mem[i]=32'hA000_0000+i, RESET_PC=0, out_ready=1: out_valid rises 2nd cycle after resetn release;
//     then out_pc=0,4,8,... / out_inst=A000_0000,A000_0001,... one per cycle, no gaps.
//  T2 Same, out_ready=0 for 10 cycles mid-stream: inst_en low after <=2 extra reads, head stable;
//     on release sequence resumes in order, no loss, no duplicate.
//  T3 Queue full + pend, redirect_pc=0x100: two idle cycles, next out_pc=0x100, out_inst=A000_0040;
//     no pre-redirect word appears after the redirect cycle.
//  T4 redirect_pc=0x103 -> out_pc=0x100, inst_addr=0x40; redirect in same cycle as pop -> popped word counted once.
//  T5 ADDR_W=17, redirect_pc=0x7FFF8: inst_addr 0x1FFFE,0x1FFFF,0x00000; out_pc 0x7FFF8,0x7FFFC,0x80000.
//  T6 1000 cycles random out_ready/redirect vs reference model; resetn pulsed low mid-run ->
//     out_valid=0 without a clock edge, restart at RESET_PC; scoreboard matches throughout.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage in front of a 1-cycle-latency BRAM: PC, read issue, and a
// 2-entry output queue presenting {pc, instruction} to decode over valid/ready.
module inst_fetch #(
    parameter int unsigned ADDR_W   = 17,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_en,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = 3;

    logic [31:0]      pc_q, pc_n;
    logic             pend_q, pend_n;
    logic [31:0]      pend_pc_q, pend_pc_n;
    logic [CNT_W-1:0] count_q, count_n, cnt_after;
    logic [31:0]      e1_pc_q, e1_pc_n;
    logic [31:0]      e1_inst_q, e1_inst_n;
    logic             valid_n;
    logic [31:0]      head_pc_n, head_inst_n;

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occ;

    assign pop   = out_valid & out_ready;
    assign push  = pend_q & ~redirect_valid;
    // Credit: words queued plus the one in flight must leave room after this cycle's pop.
    assign occ   = OCC_W'(count_q) + OCC_W'(pend_q) - OCC_W'(pop);
    assign issue = ~redirect_valid & (occ < OCC_W'(2));

    assign inst_en   = issue & resetn;
    assign inst_addr = pc_q[ADDR_W+1:2];

    // Next-state for PC, in-flight tracking and the queue (head lives in the output registers).
    always_comb begin
        pc_n        = pc_q;
        pend_n      = 1'b0;
        pend_pc_n   = pend_pc_q;
        count_n     = count_q;
        cnt_after   = count_q;
        e1_pc_n     = e1_pc_q;
        e1_inst_n   = e1_inst_q;
        valid_n     = out_valid;
        head_pc_n   = out_pc;
        head_inst_n = out_inst;

        if (redirect_valid) begin
            pc_n    = redirect_pc & ~32'h0000_0003;
            count_n = '0;
            valid_n = 1'b0;
        end else begin
            if (issue) begin
                pend_n    = 1'b1;
                pend_pc_n = pc_q;
                pc_n      = pc_q + 32'd4;
            end
            cnt_after = count_q - CNT_W'(pop);
            if (pop) begin
                head_pc_n   = e1_pc_q;
                head_inst_n = e1_inst_q;
            end
            if (push) begin
                if (cnt_after == '0) begin
                    head_pc_n   = pend_pc_q;
                    head_inst_n = inst_rdata;
                end else begin
                    e1_pc_n   = pend_pc_q;
                    e1_inst_n = inst_rdata;
                end
            end
            count_n = cnt_after + CNT_W'(push);
            valid_n = (count_n != '0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            count_q   <= '0;
            e1_pc_q   <= '0;
            e1_inst_q <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else begin
            pc_q      <= pc_n;
            pend_q    <= pend_n;
            pend_pc_q <= pend_pc_n;
            count_q   <= count_n;
            e1_pc_q   <= e1_pc_n;
            e1_inst_q <= e1_inst_n;
            out_valid <= valid_n;
            out_pc    <= head_pc_n;
            out_inst  <= head_inst_n;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: BRAM model holding A000_0000+word_index, scoreboard of the expected
// in-order {pc, inst} stream restarted on every redirect/reset.
module tb_inst_fetch;

    localparam int unsigned ADDR_W = 17;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic              clk;
    logic              resetn;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_en;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_inst;

    int unsigned n_checks;
    int unsigned n_errors;

    exp_t        exp_q[$];
    logic [31:0] gen_pc;
    logic [31:0] issue_pc;
    int unsigned since;
    logic        last_en;
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;

    inst_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .resetn(resetn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM: mem[i] = A000_0000 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (inst_en) inst_rdata <= 32'hA000_0000 + 32'(inst_addr);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        mem_word = 32'hA000_0000 + 32'(pc[ADDR_W+1:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        gen_pc   = pc & ~32'h3;
        issue_pc = pc & ~32'h3;
    endtask

    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc   = gen_pc;
            e.inst = mem_word(gen_pc);
            exp_q.push_back(e);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    // One clock cycle: drive inputs just after negedge, sample, check, advance to next negedge.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        exp_t e;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        last_en = inst_en;
        if (prev_hold) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_pc", out_pc, prev_pc);
            check("hold_inst", out_inst, prev_inst);
        end
        if (redir) check("redir_en", 32'(inst_en), 32'd0);
        else if (since == 1 || since == 2) check("bubble", 32'(out_valid), 32'd0);
        else if (since == 3) check("first_valid", 32'(out_valid), 32'd1);
        if (inst_en) begin
            check("inst_addr", 32'(inst_addr), 32'(issue_pc[ADDR_W+1:2]));
            issue_pc = issue_pc + 32'd4;
        end
        if (out_valid && rdy) begin
            top_up();
            e = exp_q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_inst", out_inst, e.inst);
        end
        prev_hold = out_valid & ~rdy & ~redir;
        prev_pc   = out_pc;
        prev_inst = out_inst;
        if (redir) begin
            restart(rpc);
            since = 0;
        end
        @(negedge clk);
        if (since < 100) since++;
    endtask

    // Asynchronous reset assertion: outputs must clear without a clock edge.
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_en", 32'(inst_en), 32'd0);
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        prev_hold = 1'b0;
        restart(32'h0);
        since = 1;
    endtask

    initial begin
        int unsigned n_en;
        n_checks = 0; n_errors = 0;
        resetn = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        prev_hold = 1'b0; since = 100; last_en = 1'b0;
        restart(32'h0);
        #2;
        do_reset();

        // T1: streaming with out_ready held high, one per cycle after fill
        for (int i = 0; i < 20; i++) begin
            if (since > 3) check("tput", 32'(out_valid), 32'd1);
            step(1'b1, 1'b0, '0);
        end

        // T2: 10-cycle stall mid-stream
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0);
            if (last_en) n_en++;
        end
        check("stall_reads", 32'(n_en <= 2), 32'd1);
        check("stall_en", 32'(last_en), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

        // T3: queue full plus pending read, then redirect to 0x100
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // T4: misaligned target, redirect in the same cycle as a pop
        step(1'b1, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // T5: BRAM word-address wrap while PC keeps counting
        step(1'b1, 1'b1, 32'h0007_FFF8);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // Back-to-back redirects: last wins
        step(1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b1, 32'h0000_0300);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // T6: random ready/redirect with a mid-run reset
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                #3;
                do_reset();
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                 $urandom & 32'h000F_FFFF);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
